// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared constants and controller state encoding for the data cache.
package data_cache_pkg;
    localparam int WORD_SIZE      = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_FETCH = 2'd2
    } state_t;
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: valid/dirty/tag/data storage for the direct-mapped cache.
// Combinational lookup and victim read port, synchronous word-write and line-fill port.
module cache_line_array #(
    parameter int WORD_SIZE  = data_cache_pkg::WORD_SIZE,
    parameter int INDEX_BITS = 2,
    localparam int TAG_BITS  = WORD_SIZE - INDEX_BITS - data_cache_pkg::OFFSET_BITS,
    localparam int LINE_BITS = data_cache_pkg::WORDS_PER_LINE * WORD_SIZE
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [INDEX_BITS-1:0]                  i_index,
    input  logic [TAG_BITS-1:0]                    i_tag,
    input  logic [data_cache_pkg::OFFSET_BITS-1:0] i_offset,
    output logic                                   o_hit,
    output logic [WORD_SIZE-1:0]                   o_word,
    output logic                                   o_victim_dirty,
    output logic [TAG_BITS-1:0]                    o_victim_tag,
    output logic [LINE_BITS-1:0]                   o_victim_line,
    input  logic                                   i_wr_word,
    input  logic [WORD_SIZE-1:0]                   i_wdata,
    input  logic                                   i_fill,
    input  logic [INDEX_BITS-1:0]                  i_fill_index,
    input  logic [TAG_BITS-1:0]                    i_fill_tag,
    input  logic [LINE_BITS-1:0]                   i_fill_line
);
    import data_cache_pkg::*;

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAG_BITS-1:0]  r_tag  [LINES];
    logic [WORD_SIZE-1:0] r_data [LINES][WORDS_PER_LINE];

    assign o_hit          = r_valid[i_index] && (r_tag[i_index] == i_tag);
    assign o_word         = r_data[i_index][i_offset];
    assign o_victim_dirty = r_valid[i_index] && r_dirty[i_index];
    assign o_victim_tag   = r_tag[i_index];

    for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_victim
        assign o_victim_line[w*WORD_SIZE +: WORD_SIZE] = r_data[i_index][w];
    end

    // Only the status bits need reset; tag and data are qualified by valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill) begin
            r_valid[i_fill_index] <= 1'b1;
            r_dirty[i_fill_index] <= 1'b0;
        end else if (i_wr_word) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill) begin
            r_tag[i_fill_index] <= i_fill_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++)
                r_data[i_fill_index][w] <= i_fill_line[w*WORD_SIZE +: WORD_SIZE];
        end else if (i_wr_word) begin
            r_data[i_index][i_offset] <= i_wdata;
        end
    end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a line-wide backing memory, with hit/miss counters.
module data_cache #(
    parameter int WORD_SIZE  = data_cache_pkg::WORD_SIZE,
    parameter int INDEX_BITS = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                              Clk,
    input  logic                                              Reset_N,
    input  logic                                              d_readC,
    input  logic                                              d_writeC,
    input  logic [WORD_SIZE-1:0]                              d_addressC,
    input  logic [WORD_SIZE-1:0]                              d_dataC_in,
    output logic [WORD_SIZE-1:0]                              d_dataC_out,
    output logic                                              d_doneM,
    output logic                                              d_readM,
    output logic                                              d_writeM,
    output logic [WORD_SIZE-1:0]                              d_addressM,
    output logic [data_cache_pkg::WORDS_PER_LINE*WORD_SIZE-1:0] d_dataM_out,
    input  logic [data_cache_pkg::WORDS_PER_LINE*WORD_SIZE-1:0] d_dataM_in,
    input  logic                                              mem_ack,
    output logic [CNT_WIDTH-1:0]                              num_hit,
    output logic [CNT_WIDTH-1:0]                              num_miss
);
    import data_cache_pkg::*;

    localparam int TAG_BITS  = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_BITS = WORDS_PER_LINE * WORD_SIZE;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                r_state;
    logic                  r_refill;
    logic [INDEX_BITS-1:0] r_index;
    logic [TAG_BITS-1:0]   r_tag;
    logic                  r_readM;
    logic                  r_writeM;
    logic [WORD_SIZE-1:0]  r_addrM;
    logic [LINE_BITS-1:0]  r_dataM;
    logic [CNT_WIDTH-1:0]  r_hit;
    logic [CNT_WIDTH-1:0]  r_miss;

    logic                   w_req;
    logic [OFFSET_BITS-1:0] w_offset;
    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic                   w_hit;
    logic [WORD_SIZE-1:0]   w_word;
    logic                   w_victim_dirty;
    logic [TAG_BITS-1:0]    w_victim_tag;
    logic [LINE_BITS-1:0]   w_victim_line;
    logic                   w_idle_hit;

    assign w_req      = d_readC || d_writeC;
    assign w_offset   = d_addressC[OFFSET_BITS-1:0];
    assign w_index    = d_addressC[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_tag      = d_addressC[WORD_SIZE-1:INDEX_BITS+OFFSET_BITS];
    assign w_idle_hit = (r_state == ST_IDLE) && w_req && w_hit;

    // A simultaneous read and write is served as a write, so no load data then.
    assign d_doneM     = w_idle_hit;
    assign d_dataC_out = (w_idle_hit && !d_writeC) ? w_word : '0;
    assign d_readM     = r_readM;
    assign d_writeM    = r_writeM;
    assign d_addressM  = r_addrM;
    assign d_dataM_out = r_dataM;
    assign num_hit     = r_hit;
    assign num_miss    = r_miss;

    cache_line_array #(
        .WORD_SIZE (WORD_SIZE),
        .INDEX_BITS(INDEX_BITS)
    ) u_lines (
        .i_clk         (Clk),
        .i_rst_n       (Reset_N),
        .i_index       (w_index),
        .i_tag         (w_tag),
        .i_offset      (w_offset),
        .o_hit         (w_hit),
        .o_word        (w_word),
        .o_victim_dirty(w_victim_dirty),
        .o_victim_tag  (w_victim_tag),
        .o_victim_line (w_victim_line),
        .i_wr_word     (w_idle_hit && d_writeC),
        .i_wdata       (d_dataC_in),
        .i_fill        ((r_state == ST_FETCH) && mem_ack),
        .i_fill_index  (r_index),
        .i_fill_tag    (r_tag),
        .i_fill_line   (d_dataM_in)
    );

    // Index and tag are latched at the miss so the refill finishes even if the CPU drops the request.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state  <= ST_IDLE;
            r_refill <= 1'b0;
            r_index  <= '0;
            r_tag    <= '0;
            r_readM  <= 1'b0;
            r_writeM <= 1'b0;
            r_addrM  <= '0;
            r_dataM  <= '0;
            r_hit    <= '0;
            r_miss   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_hit) begin
                        r_hit    <= r_refill ? r_hit : r_hit + CNT_ONE;
                        r_refill <= 1'b0;
                    end else if (w_req) begin
                        r_miss   <= r_miss + CNT_ONE;
                        r_refill <= 1'b1;
                        r_index  <= w_index;
                        r_tag    <= w_tag;
                        r_state  <= w_victim_dirty ? ST_WB : ST_FETCH;
                        r_writeM <= w_victim_dirty;
                        r_readM  <= !w_victim_dirty;
                        r_addrM  <= w_victim_dirty ? {w_victim_tag, w_index, {OFFSET_BITS{1'b0}}}
                                                   : {w_tag, w_index, {OFFSET_BITS{1'b0}}};
                        r_dataM  <= w_victim_dirty ? w_victim_line : '0;
                    end
                end
                ST_WB: begin
                    if (mem_ack) begin
                        r_state  <= ST_FETCH;
                        r_writeM <= 1'b0;
                        r_readM  <= 1'b1;
                        r_addrM  <= {r_tag, r_index, {OFFSET_BITS{1'b0}}};
                        r_dataM  <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                        r_readM <= 1'b0;
                        r_addrM <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
